// File: rtl/scan_seq_3_8.sv
// rtl/scan_seq_3_8.sv - scan sequencer driving a 3-to-8 decoder's select and enable.
// Optional SCAN_SEQ_ONESHOT_EN adds the oneshot input (stop after one frame).
module scan_seq_3_8 #(
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
`ifdef SCAN_SEQ_ONESHOT_EN
  input  logic               oneshot,
`endif
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               frame
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  // One counter serves both the blanking gap and the dwell.
  localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             frame_q, frame_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SCAN_SEQ_ONESHOT_EN
  logic             oneshot_q, oneshot_d;
`endif

  logic       first_vld, next_vld;
  logic [2:0] first_idx, next_idx;
  logic       enter;
  logic [2:0] enter_idx;
  logic       stop_pend;
  logic       wrap_to_idle;

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    first_vld = 1'b0;
    first_idx = 3'd0;
    next_vld  = 1'b0;
    next_idx  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k]) begin
        first_vld = 1'b1;
        first_idx = 3'(k);
        if (3'(k) > sel_q) begin
          next_vld = 1'b1;
          next_idx = 3'(k);
        end
      end
    end
  end

  assign stop_pend = stop_q | stop;

`ifdef SCAN_SEQ_ONESHOT_EN
  assign wrap_to_idle = oneshot_q;
`else
  assign wrap_to_idle = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_d      = en_q;
    busy_d    = busy_q;
    frame_d   = 1'b0;
    stop_d    = stop_q;
    cnt_d     = cnt_q;
    enter     = 1'b0;
    enter_idx = 3'd0;
`ifdef SCAN_SEQ_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start && !stop && first_vld) begin
          enter     = 1'b1;
          enter_idx = first_idx;
`ifdef SCAN_SEQ_ONESHOT_EN
          oneshot_d = oneshot;
`endif
        end
      end
      S_BLANK: begin
        stop_d = stop_pend;
        if (stop_pend) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_DRIVE;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(dwell);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRIVE: begin
        stop_d = stop_pend;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (stop_pend || !first_vld) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
        end else if (next_vld) begin
          enter     = 1'b1;
          enter_idx = next_idx;
        end else begin
          frame_d = 1'b1;
          if (wrap_to_idle) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            enter     = 1'b1;
            enter_idx = first_idx;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
      end
    endcase

    // With no blanking the new channel is driven straight away.
    if (enter) begin
      sel_d  = enter_idx;
      busy_d = 1'b1;
      if (BLANK == 0) begin
        state_d = S_DRIVE;
        en_d    = 1'b1;
        cnt_d   = CNT_W'(dwell);
      end else begin
        state_d = S_BLANK;
        en_d    = 1'b0;
        cnt_d   = BLANK_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= 3'd0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      stop_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef SCAN_SEQ_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
      stop_q    <= stop_d;
      cnt_q     <= cnt_d;
`ifdef SCAN_SEQ_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
    end
  end

  assign sel   = sel_q;
  assign en    = en_q;
  assign busy  = busy_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_scan_seq_3_8.sv
// tb/tb_scan_seq_3_8.sv - scoreboard bench for scan_seq_3_8 (BLANK=1, DWELL_W=8).
// Define SCAN_SEQ_ONESHOT_EN to also cover the oneshot port.
module tb_scan_seq_3_8;

  localparam int DWELL_W = 8;
  localparam int BLANK   = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               oneshot;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               frame;

  int         checks   = 0;
  int         failures = 0;
  string      cur_tag  = "";
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  scan_seq_3_8 #(
    .DWELL_W (DWELL_W),
    .BLANK   (BLANK)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
`ifdef SCAN_SEQ_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .mask    (mask),
    .dwell   (dwell),
    .sel     (sel),
    .en      (en),
    .busy    (busy),
    .frame   (frame)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel,en,busy,frame packed) at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic e, input logic b, input logic f, input int n);
    repeat (n) exp_q.push_back({s, e, b, f});
  endtask

  // One channel slot: BLANK cycles with en=0 then dwell+1 cycles with en=1.
  task automatic push_chan(input logic [2:0] ch, input int dw, input logic fr);
    push(ch, 1'b0, 1'b1, fr, 1);
    push(ch, 1'b1, 1'b1, 1'b0, dw + 1);
  endtask

  task automatic cycle();
    logic [5:0] e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(cur_tag, {sel, en, busy, frame}, e);
    end
  endtask

  task automatic run_q();
    int budget;
    budget = 500;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check_eq({cur_tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    oneshot = 1'b0;
    mask    = 8'h00;
    dwell   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset", {sel, en, busy, frame}, 0);
    rst_n = 1'b1;

    // Async reset in the third dwell cycle of channel 0.
    cur_tag = "pre_async";
    mask = 8'hFF; dwell = 8'd5; start = 1'b1;
    push(3'd0, 1'b0, 1'b1, 1'b0, 1);
    push(3'd0, 1'b1, 1'b1, 1'b0, 3);
    cycle();
    start = 1'b0;
    run_q();
    #1 rst_n = 1'b0;
    #1 check_eq("async_rst", {sel, en, busy, frame}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full mask, dwell 0: 16-cycle frames; start accepted right after reset.
    cur_tag = "full_scan";
    mask = 8'hFF; dwell = 8'd0; start = 1'b1;
    for (int k = 0; k < 8; k++) push_chan(3'(k), 0, 1'b0);
    for (int k = 0; k < 8; k++) push_chan(3'(k), 0, k == 0);
    push_chan(3'd0, 0, 1'b1);
    cycle();
    start = 1'b0;
    run_q();
    stop = 1'b1;
    push(3'd0, 1'b0, 1'b0, 1'b0, 1);
    cycle();
    stop = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0, 2);
    run_q();

    // Sparse mask; mask change during channel 5 only acts at its advance.
    cur_tag = "sparse";
    mask = 8'hA4; dwell = 8'd3; start = 1'b1;
    push_chan(3'd2, 3, 1'b0);
    push_chan(3'd5, 3, 1'b0);
    push_chan(3'd7, 3, 1'b0);
    push_chan(3'd2, 3, 1'b1);
    push(3'd5, 1'b0, 1'b1, 1'b0, 1);
    cycle();
    start = 1'b0;
    run_q();
    mask = 8'h01;
    cur_tag = "mask_change";
    push(3'd5, 1'b1, 1'b1, 1'b0, 4);
    push_chan(3'd0, 3, 1'b1);
    push(3'd0, 1'b0, 1'b1, 1'b1, 1);
    push(3'd0, 1'b1, 1'b1, 1'b0, 1);
    run_q();
    cur_tag = "stop_drive";
    stop = 1'b1;
    push(3'd0, 1'b1, 1'b1, 1'b0, 3);
    push(3'd0, 1'b0, 1'b0, 1'b0, 2);
    cycle();
    stop = 1'b0;
    run_q();

    // Stop during blanking: channel 3 is never driven.
    cur_tag = "stop_blank";
    mask = 8'h08; dwell = 8'd2; start = 1'b1;
    push(3'd3, 1'b0, 1'b1, 1'b0, 1);
    cycle();
    start = 1'b0; stop = 1'b1;
    push(3'd3, 1'b0, 1'b0, 1'b0, 1);
    cycle();
    stop = 1'b0;
    push(3'd3, 1'b0, 1'b0, 1'b0, 3);
    run_q();

    cur_tag = "start_mask0";
    mask = 8'h00; start = 1'b1;
    push(3'd3, 1'b0, 1'b0, 1'b0, 3);
    cycle();
    start = 1'b0;
    run_q();

    cur_tag = "start_stop";
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    push(3'd3, 1'b0, 1'b0, 1'b0, 3);
    cycle();
    start = 1'b0; stop = 1'b0;
    run_q();

    // A second start during channel 1's drive must not restart the scan.
    cur_tag = "start_busy";
    mask = 8'h06; dwell = 8'd1; start = 1'b1;
    push_chan(3'd1, 1, 1'b0);
    push_chan(3'd2, 1, 1'b0);
    push_chan(3'd1, 1, 1'b1);
    cycle();
    start = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_q();
    stop = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0, 1);
    cycle();
    stop = 1'b0;
    push(3'd1, 1'b0, 1'b0, 1'b0, 2);
    run_q();

`ifdef SCAN_SEQ_ONESHOT_EN
    cur_tag = "oneshot";
    mask = 8'h81; dwell = 8'd1; oneshot = 1'b1; start = 1'b1;
    push_chan(3'd0, 1, 1'b0);
    push_chan(3'd7, 1, 1'b0);
    push(3'd7, 1'b0, 1'b0, 1'b1, 1);
    push(3'd7, 1'b0, 1'b0, 1'b0, 4);
    cycle();
    start = 1'b0; oneshot = 1'b0;
    run_q();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_seq_3_8.md
# scan_seq_3_8

Scan sequencer feeding a 3-to-8 decoder: generates the 3-bit select and the enable that drive the decoder's `I[2:0]` and `En` inputs. It steps through the channels enabled in an 8-bit mask, holding each one for a programmable dwell time with a blanking gap between channels. It reports a frame boundary each time the scan wraps, and runs until stopped. It sits directly upstream of the decoder in LED/keypad scan datapaths.

## Interface
- `DWELL_W`, default 8: width of the `dwell` input.
- `BLANK`, default 1: blanking cycles (en=0) before each channel's drive; legal range 0..15.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin scanning; sampled only in IDLE.
- `stop`  in  1: request stop; sampled every cycle while busy.
- `mask`  in  8: channel enable mask; bit k=1 means channel k is scanned.
- `dwell`  in  DWELL_W: drive length minus one, in cycles.
- `sel`  out  3: channel index, to decoder `I`.
- `en`  out  1: drive enable, to decoder `En`.
- `busy`  out  1: high whenever the state is not IDLE.
- `frame`  out  1: one-cycle pulse on scan wrap.

## Operation
- Reset values: state IDLE, sel=0, en=0, busy=0, frame=0, stop latch cleared. All outputs are registered.
- States and transitions:
  - IDLE → BLANK on start=1 with mask≠0 and stop=0. sel loads the lowest set bit of mask. If BLANK=0, IDLE goes directly to DRIVE.
  - BLANK: en=0 for BLANK cycles, then → DRIVE.
  - DRIVE: en=1 for dwell+1 cycles. dwell is captured on DRIVE entry, so dwell=0 gives 1 cycle. At the end of DRIVE the sequencer advances.
- Advance:
  - Search mask as sampled in the last DRIVE cycle for the lowest set bit with index > sel.
  - If no such bit exists, wrap to the lowest set bit overall and pulse frame.
  - If mask=0 at advance, → IDLE with no frame pulse.
- Mask changes during BLANK/DRIVE have no effect until the next advance.
- A single-bit mask re-drives the same channel every frame, with a frame pulse on every advance.
- Stop handling:
  - stop=1 in any busy cycle sets a latch.
  - In BLANK, a pending stop forces → IDLE on the next edge; en never rises for that channel.
  - In DRIVE, the current dwell completes, then → IDLE instead of advancing. No frame pulse occurs even if the advance would have wrapped.
- In IDLE, sel holds its last value and en=0.
- Start/stop conflicts:
  - start while busy is ignored.
  - start and stop together in IDLE: stop wins and the block stays IDLE.
  - start with mask=0 is ignored.

## Timing
- start sampled at edge T: from T+ busy=1, sel=first channel, en=0 for BLANK cycles. en=1 from edge T+BLANK for dwell+1 cycles.
- Per-channel period: BLANK+dwell+1 cycles. sel changes only on the edge that leaves DRIVE.
- frame is high for exactly the one cycle following the last DRIVE cycle of the wrapping channel, concurrent with the first BLANK/DRIVE cycle of the new frame.
- Returning to IDLE: busy and en fall on the same edge.
- rst_n low forces all outputs to reset values immediately, without waiting for a clock edge. The first start is accepted at the first edge after rst_n deasserts.

## Configuration
- `SCAN_SEQ_ONESHOT_EN`:
  - Defined: adds input `oneshot` (1 bit), captured together with start.
    - If captured high, the wrap advance pulses frame and goes → IDLE instead of continuing.
    - stop keeps its behaviour in this mode.
  - Undefined: the port is absent; scanning free-runs until stop or mask=0.

## Test plan
- Async reset mid-DRIVE, with mask=8'hFF, dwell=5, in the third dwell cycle: pull rst_n low between edges → en=0, sel=0, busy=0, frame=0 immediately.
- mask=8'hFF, dwell=0, BLANK=1, start → sel 0..7 each showing en pattern 0,1; 16-cycle frame period; frame pulses once per 16 cycles, starting the cycle after sel=7's drive.
- mask=8'b1010_0100, dwell=3 → sel sequence 2,5,7,2,…; en high exactly 4 cycles per channel; frame after each channel-7 drive. Changing mask to 8'h01 during channel 5 → next sel=0 (wrap, frame pulse).
- stop during BLANK of channel 3 → IDLE next edge, en never high for 3. stop during dwell cycle 1 of 4 → en stays high for all 4 cycles, then busy=0 with no frame.
- start with mask=0 → busy stays 0. start+stop in the same cycle → busy stays 0. start while busy → sequence unchanged.
- With SCAN_SEQ_ONESHOT_EN: oneshot=1, mask=8'h81, dwell=1 → drives channel 0 then 7, frame pulse, busy falls on the same edge; no further en.
